// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: one CPU load/store at a time through TLB lookup,
// page-table walk, TLB refill and cache access, with timeout and miss/fault counters.
module mem_access_ctrl #(
  parameter int VA_W    = 14,
  parameter int OFF_W   = 8,
  parameter int PPN_W   = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_write,
  input  logic [VA_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic                    cpu_ready,
  output logic                    cpu_resp_valid,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_hit,
  output logic                    cpu_pg_fault,
  output logic                    cpu_err,
  output logic                    tlb_lookup,
  output logic [VA_W-OFF_W-1:0]   tlb_vpn,
  input  logic                    tlb_hit,
  input  logic [PPN_W-1:0]        tlb_ppn,
  output logic                    tlb_fill,
  output logic [PPN_W-1:0]        tlb_fill_ppn,
  output logic                    tlb_dirty,
  output logic                    pt_req,
  input  logic                    pt_valid,
  input  logic                    pt_fault,
  input  logic [PPN_W-1:0]        pt_ppn,
  output logic                    cache_req,
  output logic                    cache_write,
  output logic [PPN_W+OFF_W-1:0]  cache_paddr,
  output logic [DATA_W-1:0]       cache_wdata,
  input  logic                    cache_done,
  input  logic                    cache_hit,
  input  logic [DATA_W-1:0]       cache_rdata,
  output logic [CNT_W-1:0]        tlb_miss_cnt,
  output logic [CNT_W-1:0]        fault_cnt
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, TLB, WALK, FILL, CACHE, RESP} state_t;

  state_t              state;
  logic                write_r;
  logic [VA_W-1:0]     addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   rdata_r;
  logic [PPN_W-1:0]    ppn_r;
  logic                tlb_hit_r;
  logic                cache_hit_r;
  logic                pg_fault_r;
  logic                err_r;
  logic [TMR_W-1:0]    timer;
  logic                timer_last;

  // Timeout fires on the TIMEOUT-th waiting cycle unless valid/done arrives in it.
  assign timer_last = (timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      write_r      <= 1'b0;
      addr_r       <= '0;
      wdata_r      <= '0;
      rdata_r      <= '0;
      ppn_r        <= '0;
      tlb_hit_r    <= 1'b0;
      cache_hit_r  <= 1'b0;
      pg_fault_r   <= 1'b0;
      err_r        <= 1'b0;
      timer        <= '0;
      tlb_miss_cnt <= '0;
      fault_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            write_r     <= cpu_write;
            addr_r      <= cpu_addr;
            wdata_r     <= cpu_wdata;
            rdata_r     <= '0;
            ppn_r       <= '0;
            tlb_hit_r   <= 1'b0;
            cache_hit_r <= 1'b0;
            pg_fault_r  <= 1'b0;
            err_r       <= 1'b0;
            state       <= TLB;
          end
        end
        TLB: begin
          timer <= '0;
          if (tlb_hit) begin
            ppn_r     <= tlb_ppn;
            tlb_hit_r <= 1'b1;
            state     <= CACHE;
          end else begin
            if (tlb_miss_cnt != '1) tlb_miss_cnt <= tlb_miss_cnt + 1'b1;
            state <= WALK;
          end
        end
        WALK: begin
          if (pt_valid) begin
            if (pt_fault) begin
              if (fault_cnt != '1) fault_cnt <= fault_cnt + 1'b1;
              pg_fault_r <= 1'b1;
              state      <= RESP;
            end else begin
              ppn_r <= pt_ppn;
              state <= FILL;
            end
          end else if (timer_last) begin
            err_r <= 1'b1;
            state <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FILL: begin
          timer <= '0;
          state <= CACHE;
        end
        CACHE: begin
          if (cache_done) begin
            cache_hit_r <= cache_hit;
            if (!write_r) rdata_r <= cache_rdata;
            state <= RESP;
          end else if (timer_last) begin
            err_r <= 1'b1;
            state <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from the state register, so reset drops them at once.
  assign cpu_ready      = (state == IDLE);
  assign cpu_resp_valid = (state == RESP);
  assign cpu_rdata      = (state == RESP) ? rdata_r : '0;
  assign cpu_hit        = (state == RESP) & tlb_hit_r & cache_hit_r;
  assign cpu_pg_fault   = (state == RESP) & pg_fault_r;
  assign cpu_err        = (state == RESP) & err_r;

  assign tlb_lookup     = (state == TLB);
  assign tlb_vpn        = addr_r[VA_W-1:OFF_W];
  assign tlb_fill       = (state == FILL);
  assign tlb_fill_ppn   = ppn_r;
  assign tlb_dirty      = (state == FILL) & write_r;

  assign pt_req         = (state == WALK);

  assign cache_req      = (state == CACHE);
  assign cache_write    = write_r;
  assign cache_paddr    = {ppn_r, addr_r[OFF_W-1:0]};
  assign cache_wdata    = wdata_r;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences one CPU load/store at a time through the virtual-memory hierarchy: TLB lookup, page-table walk on a TLB miss, TLB refill, then cache access.
- The cache reports completion, including any main-memory refill or writeback it performs.
- Sits between the CPU port and the TLB, page-table, cache and memory subsystem.
- Replaces the combinational chaining with an explicit FSM, request/response handshakes, a walk/access timeout and performance counters.

Parameters:
- VA_W, 14, virtual address width; VPN = VA[13:8].
- OFF_W, 8, page-offset width.
- PPN_W, 2, physical page number width; PA = {PPN, offset}, 10 bits.
- DATA_W, 32, data word width.
- TIMEOUT, 64, maximum cycles to wait for pt_valid or cache_done.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  request valid.
- cpu_write  in  1  1 = store, 0 = load.
- cpu_addr  in  14  virtual address.
- cpu_wdata  in  32  store data.
- cpu_ready  out  1  controller idle; a request is accepted when cpu_req & cpu_ready.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_rdata  out  32  load data, valid with cpu_resp_valid.
- cpu_hit  out  1  TLB hit AND cache hit, valid with cpu_resp_valid.
- cpu_pg_fault  out  1  page fault, valid with cpu_resp_valid.
- cpu_err  out  1  timeout error, valid with cpu_resp_valid.
- tlb_lookup  out  1  TLB lookup strobe.
- tlb_vpn  out  6  lookup/fill VPN.
- tlb_hit  in  1  combinational hit, sampled in the TLB state.
- tlb_ppn  in  2  PPN on hit.
- tlb_fill  out  1  TLB write strobe.
- tlb_fill_ppn  out  2  PPN to install.
- tlb_dirty  out  1  dirty bit for the fill (= stored cpu_write).
- pt_req  out  1  page-table read request, held until pt_valid.
- pt_valid  in  1  page-table response.
- pt_fault  in  1  page not present, qualified by pt_valid.
- pt_ppn  in  2  PPN, qualified by pt_valid.
- cache_req  out  1  cache access request, held until cache_done.
- cache_write  out  1  access type.
- cache_paddr  out  10  physical address.
- cache_wdata  out  32  store data.
- cache_done  in  1  access complete (includes main-memory refill).
- cache_hit  in  1  hit flag, qualified by cache_done.
- cache_rdata  in  32  read data, qualified by cache_done.
- tlb_miss_cnt  out  CNT_W  saturating count of TLB misses.
- fault_cnt  out  CNT_W  saturating count of page faults.

Behaviour:
- Reset values: state IDLE; cpu_ready=1; all strobes, response outputs and counters 0; latched request registers 0.
- Reset asserted mid-operation abandons the transaction immediately. No response is produced, and pt_req/cache_req drop asynchronously.
- Acceptance: on cpu_req & cpu_ready, latch write, addr and wdata, then go to TLB. cpu_ready=0 in every state except IDLE.
- Inputs from the CPU that change after acceptance are ignored.
- States:
  - IDLE: wait for acceptance.
  - TLB (1 cycle): tlb_lookup=1, tlb_vpn=addr[13:8]. On tlb_hit, latch ppn=tlb_ppn, set tlb_hit_r=1, go to CACHE. Otherwise increment tlb_miss_cnt and go to WALK.
  - WALK: pt_req=1 and the timer counts. On pt_valid & pt_fault, increment fault_cnt and go to RESP with pg_fault=1. On pt_valid & !pt_fault, latch pt_ppn and go to FILL. If the timer reaches TIMEOUT, go to RESP with err=1.
  - FILL (1 cycle): tlb_fill=1, tlb_vpn=VPN, tlb_fill_ppn=ppn, tlb_dirty=write. Then go to CACHE.
  - CACHE: cache_req=1, cache_paddr={ppn, addr[7:0]}, cache_write and cache_wdata from the latched request, and the timer counts. On cache_done, latch rdata and hit, then go to RESP. On timeout, go to RESP with err=1.
  - RESP (1 cycle): cpu_resp_valid=1. Then go to IDLE with cpu_ready=1.
- Response fields:
  - cpu_hit = tlb_hit_r & cache_hit_r.
  - cpu_rdata = 0 for stores, faults and errors.
  - cpu_pg_fault and cpu_err are never both 1.
- Timer: cleared on entry to WALK and on entry to CACHE. Timeout fires when the timer equals TIMEOUT-1 with no done/valid in that cycle.
- Simultaneous events: done/valid arriving in the same cycle as the timeout wins. No cache access is issued on a fault or a walk timeout.
- Counters saturate at all-ones and do not wrap. A TLB miss and a fault in the same transaction each count once.
- Latency, counted from the acceptance edge: TLB hit plus cache done in the first CACHE cycle gives cpu_resp_valid 3 cycles later. A TLB miss adds 2 + (pt_valid delay) cycles.
- A new request can be accepted in the cycle after RESP. No pipelining and no back-to-back overlap.

Test Plan:
- Load hit path: addr=0x1234 (VPN 0x12, off 0x34); tlb_hit=1, ppn=2; cache_done+hit in first CACHE cycle, rdata=0xDEADBEEF. Required: cache_paddr=0x234, resp 3 cycles after acceptance with rdata=0xDEADBEEF, cpu_hit=1, tlb_miss_cnt=0.
- TLB miss with walk: tlb_hit=0; pt_valid after 4 cycles with ppn=1. Required: one tlb_fill pulse with vpn 0x12, ppn 1; cache_paddr=0x134; cpu_hit=0; tlb_miss_cnt=1.
- Page fault on a store: pt_valid with pt_fault=1. Required: no cache_req ever asserted; cpu_pg_fault=1; fault_cnt=1; cpu_rdata=0.
- Timeout: cache_done never asserted with TIMEOUT=64. Required: cpu_err=1 exactly 64 cycles after CACHE entry; cache_req deasserts; cpu_ready=1 next cycle. A repeat run with cache_done arriving on cycle 64 must give a normal response.
- Reset mid-walk: assert rst while in WALK. Required: pt_req=0 immediately, counters=0, no cpu_resp_valid, cpu_ready=1 after release.
- Back-to-back plus saturation: hold cpu_req high for 3 requests. Required: each is accepted only while cpu_ready=1. Preload tlb_miss_cnt=0xFFFF via forced misses; a further miss keeps it at 0xFFFF.
